pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It arbitrates between load-use stalls, multiply/divide busy stalls, data-memory wait freezes and exception flushes. It contains the multi-cycle MDU busy timer, which issues the HI/LO write strobe, and two saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_stall_ctrl_mdu_timer.sv | 75 +++++++
 rtl/pipe_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   mdu_state_e    : MDU busy-timer states (IDLE, MUL, DIV)
//   MUL_CYCLES_DEF : default busy cycles for mult/multu
//   DIV_CYCLES_DEF : default busy cycles for div/divu
//   MDU_CNT_W      : width of the MDU down-counter
//   PERF_SAT       : value at which the performance counters stop counting
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;
  localparam int unsigned MDU_CNT_W      = 4;
  localparam logic [31:0] PERF_SAT       = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_stall_ctrl_mdu_timer.sv
// Multi-cycle multiply/divide busy timer.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   mdu_start_E  : valid mult/multu/div/divu in E
//   mdu_is_div_E : 1 = divide, 0 = multiply (qualified by mdu_start_E)
//   exc_req_M    : exception in M; suppresses a start in the same cycle
//   mdu_busy     : MDU occupied, including the start cycle
//   hilo_we      : one-cycle HI/LO write strobe in the last busy cycle
import pipe_ctrl_pkg::*;

module mdu_timer #(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic mdu_start_E,
  input  logic mdu_is_div_E,
  input  logic exc_req_M,
  output logic mdu_busy,
  output logic hilo_we
);

  localparam logic [MDU_CNT_W-1:0] MUL_LD = MDU_CNT_W'(MUL_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_LD = MDU_CNT_W'(DIV_CYCLES);

  mdu_state_e             state_q, state_d;
  logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   start_ok;

  // An instruction flushed by an exception in the same cycle never starts.
  assign start_ok = mdu_start_E & ~exc_req_M;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hilo_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = mdu_is_div_E ? DIV : MUL;
          cnt_d   = mdu_is_div_E ? DIV_LD : MUL_LD;
        end
      end
      MUL, DIV: begin
        // Keeps counting through dm_wait freezes and exceptions; a start
        // seen here is ignored because decode never lets it happen.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == MDU_CNT_W'(1)) begin
          hilo_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy already in the start cycle so a following mfhi in D stalls at once;
  // gated by reset so nothing is reported while the controller is held.
  assign mdu_busy = reset & ((state_q != IDLE) | start_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
//   clk, reset             : clock (rising edge), async active-low reset
//   hazard_D               : load-use hazard in decode
//   mdu_start_E            : mult/div starts in E
//   mdu_is_div_E           : 1 = div/divu, 0 = mult/multu
//   mdu_use_D              : instruction in D touches HI/LO or the MDU
//   dm_wait                : data memory not ready, freeze the pipeline
//   exc_req_M              : exception taken on the instruction in M
//   en_F/en_D/en_E/en_M    : enables for PC, IF/ID, ID/EX, EX/MEM
//   clr_D/clr_E/clr_M/clr_W: synchronous bubble of IF/ID, ID/EX, EX/MEM, MEM/WB
//   mdu_busy, hilo_we      : MDU occupancy and HI/LO write strobe
//   stall_cnt, freeze_cnt  : saturating stall / freeze cycle counters
import pipe_ctrl_pkg::*;

module pipe_stall_ctrl #(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_D,
  input  logic        mdu_start_E,
  input  logic        mdu_is_div_E,
  input  logic        mdu_use_D,
  input  logic        dm_wait,
  input  logic        exc_req_M,
  output logic        en_F,
  output logic        en_D,
  output logic        en_E,
  output logic        en_M,
  output logic        clr_D,
  output logic        clr_E,
  output logic        clr_M,
  output logic        clr_W,
  output logic        mdu_busy,
  output logic        hilo_we,
  output logic [31:0] stall_cnt,
  output logic [31:0] freeze_cnt
);

  logic        mdu_stall;
  logic        stall;
  logic        stall_inc;
  logic        freeze_inc;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != PERF_SAT)) ? v + 32'd1 : v;
  endfunction

  mdu_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .mdu_start_E  (mdu_start_E),
    .mdu_is_div_E (mdu_is_div_E),
    .exc_req_M    (exc_req_M),
    .mdu_busy     (mdu_busy),
    .hilo_we      (hilo_we)
  );

  assign mdu_stall = mdu_use_D & mdu_busy;
  assign stall     = hazard_D | mdu_stall;

  // Priority: exception flush > memory freeze > decode stall > run.
  always_comb begin
    en_F  = 1'b1;
    en_D  = 1'b1;
    en_E  = 1'b1;
    en_M  = 1'b1;
    clr_D = 1'b0;
    clr_E = 1'b0;
    clr_M = 1'b0;
    clr_W = 1'b0;
    if (!reset) begin
      en_F = 1'b0;
      en_D = 1'b0;
      en_E = 1'b0;
      en_M = 1'b0;
    end else if (exc_req_M) begin
      // Younger instructions are squashed; the one in M becomes a bubble
      // while W still retires.
      clr_D = 1'b1;
      clr_E = 1'b1;
      clr_M = 1'b1;
    end else if (dm_wait) begin
      // Everything holds; W is bubbled so the instruction there does not
      // write back twice.
      en_F  = 1'b0;
      en_D  = 1'b0;
      en_E  = 1'b0;
      en_M  = 1'b0;
      clr_W = 1'b1;
    end else if (stall) begin
      en_F  = 1'b0;
      en_D  = 1'b0;
      clr_E = 1'b1;
    end
  end

  assign stall_inc  = stall & ~exc_req_M & ~dm_wait;
  assign freeze_inc = dm_wait & ~exc_req_M;

  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, stall_inc);
    freeze_cnt_d = sat_inc(freeze_cnt_q, freeze_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        reset;
  logic        hazard_D;
  logic        mdu_start_E;
  logic        mdu_is_div_E;
  logic        mdu_use_D;
  logic        dm_wait;
  logic        exc_req_M;
  logic        en_F, en_D, en_E, en_M;
  logic        clr_D, clr_E, clr_M, clr_W;
  logic        mdu_busy;
  logic        hilo_we;
  logic [31:0] stall_cnt;
  logic [31:0] freeze_cnt;
  logic [7:0]  ctl;

  int passed = 0;
  int total  = 0;

  localparam logic [7:0] CTL_OFF    = 8'b0000_0000;
  localparam logic [7:0] CTL_RUN    = 8'b1111_0000;
  localparam logic [7:0] CTL_STALL  = 8'b0011_0100;
  localparam logic [7:0] CTL_FREEZE = 8'b0000_0001;
  localparam logic [7:0] CTL_EXC    = 8'b1111_1110;

  // {en_F, en_D, en_E, en_M, clr_D, clr_E, clr_M, clr_W}
  assign ctl = {en_F, en_D, en_E, en_M, clr_D, clr_E, clr_M, clr_W};

  pipe_stall_ctrl #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_D     (hazard_D),
    .mdu_start_E  (mdu_start_E),
    .mdu_is_div_E (mdu_is_div_E),
    .mdu_use_D    (mdu_use_D),
    .dm_wait      (dm_wait),
    .exc_req_M    (exc_req_M),
    .en_F         (en_F),
    .en_D         (en_D),
    .en_E         (en_E),
    .en_M         (en_M),
    .clr_D        (clr_D),
    .clr_E        (clr_E),
    .clr_M        (clr_M),
    .clr_W        (clr_W),
    .mdu_busy     (mdu_busy),
    .hilo_we      (hilo_we),
    .stall_cnt    (stall_cnt),
    .freeze_cnt   (freeze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic h, input logic s, input logic d,
                       input logic u, input logic w, input logic e);
    hazard_D     = h;
    mdu_start_E  = s;
    mdu_is_div_E = d;
    mdu_use_D    = u;
    dm_wait      = w;
    exc_req_M    = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 0);
    #1;
    total++;
    if (ctl !== CTL_OFF) $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_OFF);
    else passed++;
    total++;
    if (mdu_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", mdu_busy);
    else passed++;
    total++;
    if (hilo_we !== 1'b0) $display("FAIL reset_hilo got=%b exp=0", hilo_we);
    else passed++;
    total++;
    if (stall_cnt !== 32'd0 || freeze_cnt !== 32'd0)
      $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, freeze_cnt);
    else passed++;
    do_reset();
    #1;
    total++;
    if (ctl !== CTL_RUN) $display("FAIL idle_ctl got=%b exp=%b", ctl, CTL_RUN);
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive((t == 1), 0, 0, 0, 0, 0);
      #1;
      total++;
      if (ctl !== ((t == 1) ? CTL_STALL : CTL_RUN))
        $display("FAIL load_use_ctl t=%0d got=%b exp=%b", t, ctl,
                 (t == 1) ? CTL_STALL : CTL_RUN);
      else passed++;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (stall_cnt !== 32'd1) $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    else passed++;
  endtask

  task automatic test_mult_mfhi();
    do_reset();
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      drive(0, (t == 10), 0, (t >= 11), 0, 0);
      #1;
      total++;
      if (mdu_busy !== (t >= 10 && t <= 15))
        $display("FAIL mult_busy t=%0d got=%b exp=%b", t, mdu_busy, (t >= 10 && t <= 15));
      else passed++;
      total++;
      if (hilo_we !== (t == 15))
        $display("FAIL mult_hilo t=%0d got=%b exp=%b", t, hilo_we, (t == 15));
      else passed++;
      total++;
      if (ctl !== ((t >= 11 && t <= 15) ? CTL_STALL : CTL_RUN))
        $display("FAIL mult_ctl t=%0d got=%b exp=%b", t, ctl,
                 (t >= 11 && t <= 15) ? CTL_STALL : CTL_RUN);
      else passed++;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (stall_cnt !== 32'd5) $display("FAIL mult_stall_cnt got=%0d exp=5", stall_cnt);
    else passed++;
  endtask

  task automatic test_div_freeze();
    do_reset();
    for (int t = 0; t < 13; t++) begin
      // hazard at t=4 is masked by the freeze and must not count as a stall
      @(negedge clk);
      drive((t == 4), (t == 0), 1, 0, (t >= 3 && t <= 6), 0);
      #1;
      total++;
      if (ctl !== ((t >= 3 && t <= 6) ? CTL_FREEZE : CTL_RUN))
        $display("FAIL div_ctl t=%0d got=%b exp=%b", t, ctl,
                 (t >= 3 && t <= 6) ? CTL_FREEZE : CTL_RUN);
      else passed++;
      total++;
      if (hilo_we !== (t == 10))
        $display("FAIL div_hilo t=%0d got=%b exp=%b", t, hilo_we, (t == 10));
      else passed++;
      total++;
      if (mdu_busy !== (t <= 10))
        $display("FAIL div_busy t=%0d got=%b exp=%b", t, mdu_busy, (t <= 10));
      else passed++;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (freeze_cnt !== 32'd4) $display("FAIL div_freeze_cnt got=%0d exp=4", freeze_cnt);
    else passed++;
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL div_stall_cnt got=%0d exp=0", stall_cnt);
    else passed++;
  endtask

  task automatic test_exception();
    do_reset();
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      drive((t == 0), (t == 0), 1, (t == 0), (t == 0), (t == 0));
      #1;
      total++;
      if (ctl !== ((t == 0) ? CTL_EXC : CTL_RUN))
        $display("FAIL exc_ctl t=%0d got=%b exp=%b", t, ctl, (t == 0) ? CTL_EXC : CTL_RUN);
      else passed++;
      total++;
      if (mdu_busy !== 1'b0 || hilo_we !== 1'b0)
        $display("FAIL exc_mdu t=%0d got=%b%b exp=00", t, mdu_busy, hilo_we);
      else passed++;
    end
    total++;
    if (stall_cnt !== 32'd0 || freeze_cnt !== 32'd0)
      $display("FAIL exc_cnt got=%0d/%0d exp=0/0", stall_cnt, freeze_cnt);
    else passed++;
    // exception while a multiply is running leaves the timer alone
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      drive(0, (t == 0), 0, 0, 0, (t == 2));
      #1;
      total++;
      if (hilo_we !== (t == 5))
        $display("FAIL exc_mul_hilo t=%0d got=%b exp=%b", t, hilo_we, (t == 5));
      else passed++;
      total++;
      if (ctl !== ((t == 2) ? CTL_EXC : CTL_RUN))
        $display("FAIL exc_mul_ctl t=%0d got=%b exp=%b", t, ctl, (t == 2) ? CTL_EXC : CTL_RUN);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      drive(0, (t == 0), 1, 0, 0, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    #1;
    total++;
    if (ctl !== CTL_OFF || mdu_busy !== 1'b0 || hilo_we !== 1'b0)
      $display("FAIL rst_mid got=%b/%b%b exp=%b/00", ctl, mdu_busy, hilo_we, CTL_OFF);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int t = 6; t < 15; t++) begin
      @(negedge clk);
      #1;
      total++;
      if (hilo_we !== 1'b0 || mdu_busy !== 1'b0)
        $display("FAIL rst_abort t=%0d got=%b%b exp=00", t, mdu_busy, hilo_we);
      else passed++;
    end
    for (int u = 0; u < 7; u++) begin
      @(negedge clk);
      drive(0, (u == 0), 0, 0, 0, 0);
      #1;
      total++;
      if (hilo_we !== (u == 5) || mdu_busy !== (u <= 5))
        $display("FAIL rst_new_mul u=%0d got=%b%b exp=%b%b", u, mdu_busy, hilo_we,
                 (u <= 5), (u == 5));
      else passed++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.stall_cnt_q;
    @(negedge clk);
    total++;
    if (stall_cnt !== 32'hFFFF_FFFE) $display("FAIL sat_preload got=%h exp=fffffffe", stall_cnt);
    else passed++;
    for (int t = 0; t < 3; t++) begin
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if (stall_cnt !== 32'hFFFF_FFFF)
        $display("FAIL sat_cnt t=%0d got=%h exp=ffffffff", t, stall_cnt);
      else passed++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_mult_mfhi();
    test_div_freeze();
    test_exception();
    test_reset_mid_div();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
